// File: rtl/l1a_window_capture_if.sv
// Bundle between the L1A capture block and its neighbours: delayed hit data,
// trigger controls and the FWFT readout port of the event FIFO.
interface l1a_window_capture_if #(
  parameter int DW = 34,
  parameter int NW = 12
);
  logic [DW-1:0] din;
  logic          valorr;
  logic          l1a;
  logic [3:0]    l1a_window;
  logic [NW-1:0] bxn;
  logic          trig_stop;
  logic          rd_en;
  logic [DW:0]   dout;
  logic          empty;
  logic          full;
  logic          overflow;
  logic          busy;
  logic [NW-1:0] l1a_num;
  logic [7:0]    l1a_lost;

  // Driver side: delay buffer / trigger / DAQ readout
  modport master (
    output din, valorr, l1a, l1a_window, bxn, trig_stop, rd_en,
    input  dout, empty, full, overflow, busy, l1a_num, l1a_lost
  );

  // Capture block side
  modport slave (
    input  din, valorr, l1a, l1a_window, bxn, trig_stop, rd_en,
    output dout, empty, full, overflow, busy, l1a_num, l1a_lost
  );
endinterface

// File: rtl/l1a_window_capture.sv
// L1A window capture: on each accepted L1A writes a header word followed by
// W delayed data words into a FWFT readout FIFO. Tracks the L1A number,
// sticky overflow and L1As lost while a capture is in progress.
module l1a_window_capture #(
  parameter int DW = 34,
  parameter int AW = 6,
  parameter int NW = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  l1a_window_capture_if.slave  bus
);

  localparam int DEPTH = 2 ** AW;
  // Zero field between the L1A number and the BXN in the header
  localparam int PADW  = DW - 5 - 2 * NW;

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  state_t        state_reg;
  logic [3:0]    w_reg;
  logic [3:0]    cnt_reg;
  logic          match_reg;
  logic [NW-1:0] bxn_reg;
  logic [NW-1:0] num_lat_reg;
  logic [NW-1:0] l1a_num_reg;
  logic [7:0]    lost_reg;
  logic          overflow_reg;
  logic          busy_reg;

  logic [DW:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic [DW:0]   hold_reg;

  logic [3:0]    w_eff;
  logic [AW:0]   free_space;
  logic          admit;
  logic          wr_fire;
  logic          rd_fire;
  logic [DW:0]   wr_data;
  logic [DW:0]   header;

  // Window decode, admission check and FIFO write/read qualification
  always_comb begin
    w_eff      = (bus.l1a_window == 4'd0) ? 4'd10 : bus.l1a_window;
    free_space = (AW + 1)'(DEPTH) - count_reg;
    admit      = free_space >= ((AW + 1)'(w_eff) + (AW + 1)'(1));
    header     = {1'b1, match_reg, w_reg, num_lat_reg, {PADW{1'b0}}, bxn_reg};
    wr_fire    = ((state_reg == HDR) || (state_reg == DATA)) && !bus.trig_stop && !rst;
    wr_data    = (state_reg == HDR) ? header : {1'b0, bus.din};
    rd_fire    = bus.rd_en && (count_reg != '0);
  end

  // Capture FSM, L1A numbering and loss/overflow bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      busy_reg     <= 1'b0;
      w_reg        <= '0;
      cnt_reg      <= '0;
      match_reg    <= 1'b0;
      bxn_reg      <= '0;
      num_lat_reg  <= '0;
      l1a_num_reg  <= '0;
      lost_reg     <= '0;
      overflow_reg <= 1'b0;
    end else if (bus.trig_stop) begin
      state_reg <= IDLE;
      busy_reg  <= 1'b0;
    end else begin
      if (bus.l1a) begin
        l1a_num_reg <= l1a_num_reg + 1'b1;
      end
      if (bus.l1a && (state_reg != IDLE) && (lost_reg != 8'hFF)) begin
        lost_reg <= lost_reg + 1'b1;
      end
      case (state_reg)
        IDLE: begin
          if (bus.l1a) begin
            num_lat_reg <= l1a_num_reg;
            w_reg       <= w_eff;
            match_reg   <= bus.valorr;
            bxn_reg     <= bus.bxn;
            if (admit) begin
              state_reg <= HDR;
              busy_reg  <= 1'b1;
            end else begin
              overflow_reg <= 1'b1;
            end
          end
        end
        HDR: begin
          cnt_reg   <= w_reg;
          state_reg <= DATA;
        end
        DATA: begin
          cnt_reg <= cnt_reg - 1'b1;
          if (cnt_reg == 4'd1) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  // FIFO storage write port (no reset on the array)
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // FIFO pointers, occupancy and the value dout keeps while empty
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      hold_reg   <= '0;
    end else if (bus.trig_stop) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      if (count_reg != '0) begin
        hold_reg <= mem[rd_ptr_reg];
      end
    end else begin
      if (wr_fire) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (rd_fire) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
        hold_reg   <= mem[rd_ptr_reg];
      end
      if (wr_fire && !rd_fire) begin
        count_reg <= count_reg + 1'b1;
      end else if (!wr_fire && rd_fire) begin
        count_reg <= count_reg - 1'b1;
      end
    end
  end

  assign bus.dout     = (count_reg != '0) ? mem[rd_ptr_reg] : hold_reg;
  assign bus.empty    = (count_reg == '0);
  assign bus.full     = (count_reg == (AW + 1)'(DEPTH));
  assign bus.overflow = overflow_reg;
  assign bus.busy     = busy_reg;
  assign bus.l1a_num  = l1a_num_reg;
  assign bus.l1a_lost = lost_reg;

endmodule

// File: tb/tb_l1a_window_capture.sv
// Directed bench for l1a_window_capture: single events, default window,
// busy drops, FIFO full/overflow, trig_stop flush and reset mid-capture.
module tb_l1a_window_capture;
  localparam int DW = 34;
  localparam int AW = 6;
  localparam int NW = 12;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  l1a_window_capture_if #(.DW(DW), .NW(NW)) bus ();

  l1a_window_capture #(.DW(DW), .AW(AW), .NW(NW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fire_l1a(input logic [3:0] win, input logic v, input logic [NW-1:0] b);
    bus.l1a        = 1'b1;
    bus.l1a_window = win;
    bus.valorr     = v;
    bus.bxn        = b;
    step();
    bus.l1a = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [DW:0] exp);
    chk({tag, "_ne"}, 64'(bus.empty), 64'd0);
    chk(tag, 64'(bus.dout), 64'(exp));
    bus.rd_en = 1'b1;
    step();
    bus.rd_en = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (bus.busy && n < 50) begin
      step();
      n++;
    end
    chk(tag, 64'(n < 50), 64'd1);
  endtask

  task automatic drain(output int n);
    n = 0;
    while (!bus.empty && n < 100) begin
      bus.rd_en = 1'b1;
      step();
      n++;
    end
    bus.rd_en = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_empty"}, 64'(bus.empty), 64'd1);
    chk({tag, "_full"}, 64'(bus.full), 64'd0);
    chk({tag, "_ovf"}, 64'(bus.overflow), 64'd0);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
    chk({tag, "_num"}, 64'(bus.l1a_num), 64'd0);
    chk({tag, "_lost"}, 64'(bus.l1a_lost), 64'd0);
    chk({tag, "_dout"}, 64'(bus.dout), 64'd0);
  endtask

  initial begin
    int n;
    int nb;
    bus.din        = '0;
    bus.valorr     = 1'b0;
    bus.l1a        = 1'b0;
    bus.l1a_window = 4'd0;
    bus.bxn        = '0;
    bus.trig_stop  = 1'b0;
    bus.rd_en      = 1'b0;
    rst            = 1'b1;
    step();
    step();
    rst = 1'b0;
    check_reset("rst");

    // Event 0: W=3, match=1, bxn=0x123
    fire_l1a(4'd3, 1'b1, 12'h123);
    chk("e0_busy_hdr", 64'(bus.busy), 64'd1);
    chk("e0_num", 64'(bus.l1a_num), 64'd1);
    chk("e0_empty_hdr", 64'(bus.empty), 64'd1);
    step();
    chk("e0_hdr_vis", 64'(bus.empty), 64'd0);
    bus.din = 34'h1;
    step();
    bus.din = 34'h2;
    step();
    bus.din = 34'h3;
    step();
    chk("e0_done", 64'(bus.busy), 64'd0);
    pop_chk("e0_hdr", 35'h6_6000_0123);
    pop_chk("e0_d1", 35'h1);
    pop_chk("e0_d2", 35'h2);
    pop_chk("e0_d3", 35'h3);
    chk("e0_empty", 64'(bus.empty), 64'd1);
    chk("e0_hold", 64'(bus.dout), 64'h3);

    // Event 1: window code 0 -> W=10, match=0, bxn=0x456
    fire_l1a(4'd0, 1'b0, 12'h456);
    nb = 0;
    for (int i = 0; i < 40 && bus.busy; i++) begin
      nb++;
      bus.din = 34'h100 + 34'(i);
      step();
    end
    chk("e1_busy_cyc", 64'(nb), 64'd11);
    chk("e1_num", 64'(bus.l1a_num), 64'd2);
    pop_chk("e1_hdr", 35'h5_4002_0456);
    for (int k = 1; k <= 10; k++) begin
      pop_chk("e1_data", 35'h100 + 35'(k));
    end
    chk("e1_empty", 64'(bus.empty), 64'd1);

    // Event 2: W=15, second L1A five cycles later is dropped
    fire_l1a(4'd15, 1'b1, 12'h007);
    step();
    step();
    step();
    step();
    fire_l1a(4'd15, 1'b0, 12'h3FF);
    chk("e2_lost", 64'(bus.l1a_lost), 64'd1);
    chk("e2_num", 64'(bus.l1a_num), 64'd4);
    wait_idle("e2_idle");
    chk("e2_hdr", 64'(bus.dout), 64'h7_E004_0007);
    drain(n);
    chk("e2_words", 64'(n), 64'd16);

    // Fill: four W=15 events with no reads, fifth overflows
    for (int e = 0; e < 4; e++) begin
      fire_l1a(4'd15, 1'b1, 12'(e));
      wait_idle("fill_idle");
      step();
    end
    chk("fill_full", 64'(bus.full), 64'd1);
    chk("fill_ovf0", 64'(bus.overflow), 64'd0);
    chk("fill_num", 64'(bus.l1a_num), 64'd8);
    fire_l1a(4'd15, 1'b1, 12'h0);
    chk("ovf_set", 64'(bus.overflow), 64'd1);
    chk("ovf_busy", 64'(bus.busy), 64'd0);
    chk("ovf_full", 64'(bus.full), 64'd1);
    bus.rd_en = 1'b1;
    step();
    bus.rd_en = 1'b0;
    chk("pop1_full", 64'(bus.full), 64'd0);
    fire_l1a(4'd15, 1'b1, 12'h0);
    chk("ovf2_busy", 64'(bus.busy), 64'd0);
    chk("ovf2_full", 64'(bus.full), 64'd0);
    chk("ovf2_num", 64'(bus.l1a_num), 64'd10);

    // trig_stop flush, then abort mid-DATA with a concurrent L1A
    bus.trig_stop = 1'b1;
    step();
    bus.trig_stop = 1'b0;
    chk("ts_empty", 64'(bus.empty), 64'd1);
    chk("ts_ovf", 64'(bus.overflow), 64'd1);
    chk("ts_num", 64'(bus.l1a_num), 64'd10);
    fire_l1a(4'd5, 1'b0, 12'h055);
    step();
    chk("ts_hdr_in", 64'(bus.empty), 64'd0);
    step();
    bus.trig_stop = 1'b1;
    bus.l1a       = 1'b1;
    step();
    bus.trig_stop = 1'b0;
    bus.l1a       = 1'b0;
    chk("ts2_empty", 64'(bus.empty), 64'd1);
    chk("ts2_busy", 64'(bus.busy), 64'd0);
    chk("ts2_num", 64'(bus.l1a_num), 64'd11);
    chk("ts2_lost", 64'(bus.l1a_lost), 64'd1);
    chk("ts2_ovf", 64'(bus.overflow), 64'd1);
    fire_l1a(4'd2, 1'b1, 12'h0AA);
    step();
    bus.din = 34'h201;
    step();
    bus.din = 34'h202;
    step();
    chk("ts3_done", 64'(bus.busy), 64'd0);
    pop_chk("ts3_hdr", 35'h6_4016_00AA);
    pop_chk("ts3_d1", 35'h201);
    pop_chk("ts3_d2", 35'h202);
    chk("ts3_num", 64'(bus.l1a_num), 64'd12);

    // Reset mid-capture with rd_en and trig_stop also asserted
    fire_l1a(4'd8, 1'b1, 12'h0F0);
    step();
    step();
    rst           = 1'b1;
    bus.rd_en     = 1'b1;
    bus.trig_stop = 1'b1;
    step();
    rst           = 1'b0;
    bus.rd_en     = 1'b0;
    bus.trig_stop = 1'b0;
    check_reset("rst2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
